// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, block and byte-index types,
// and the loader's fill-side state encoding.
package aes_pkg;

  localparam int AES_BLOCK_BITS  = 128;
  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [AES_BLOCK_BITS-1:0] aes_block_t;
  typedef logic [3:0]                aes_byte_idx_t;

  // FILLING accepts bytes; BLOCKED holds a complete block waiting for the slot
  typedef enum logic {
    FILLING = 1'b0,
    BLOCKED = 1'b1
  } fill_state_t;

  localparam aes_byte_idx_t LAST_IDX = 4'd15;

endpackage

// File: rtl/aes_block_slot.sv
// Output register for a 128-bit block with valid/ready hold semantics.
// A block is loaded only while the slot is free, so out_block never
// changes while out_valid=1 and out_ready=0.
module aes_block_slot
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  aes_block_t load_block,
  input  logic       out_ready,
  output aes_block_t out_block,
  output logic       out_valid,
  output logic       slot_free
);

  assign slot_free = !out_valid || out_ready;

  // Capture a new block on load; otherwise drop valid once the consumer takes it
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_block <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_block <= load_block;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/aes_block_loader.sv
// Byte-stream to 128-bit block packer with a fill buffer and an output slot,
// so one block can fill while the previous one waits for the cipher core.
// Optional feature macro: AES_LOADER_LAST_EN adds in_last to close a block
// early, padding the remaining lanes with PAD_BYTE.
module aes_block_loader
  import aes_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef AES_LOADER_LAST_EN
  input  logic             in_last,
`endif
  output logic [127:0]     out_block,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] block_count
);

  fill_state_t   state;
  fill_state_t   state_next;
  aes_byte_idx_t idx;
  aes_block_t    fill_buf;
  aes_block_t    fill_written;
  aes_block_t    load_block;
  logic          last_flag;
  logic          accept;
  logic          close;
  logic          slot_free;
  logic          transfer;
  logic          handoff;

`ifdef AES_LOADER_LAST_EN
  assign last_flag = in_last;
`else
  assign last_flag = 1'b0;
`endif

  assign in_ready   = (state == FILLING);
  assign accept     = in_valid && in_ready;
  assign close      = accept && ((idx == LAST_IDX) || last_flag);
  assign transfer   = slot_free && ((state == BLOCKED) || close);
  assign handoff    = out_valid && out_ready;
  assign load_block = (state == BLOCKED) ? fill_buf : fill_written;

  // Fill buffer as it looks after this cycle's byte, including early-close padding
  always_comb begin
    fill_written = fill_buf;
    for (int i = 0; i < AES_BLOCK_BYTES; i++) begin
      if (aes_byte_idx_t'(i) == idx) begin
        fill_written[AES_BLOCK_BITS-8-8*i +: 8] = in_byte;
      end else if (last_flag && (aes_byte_idx_t'(i) > idx)) begin
        fill_written[AES_BLOCK_BITS-8-8*i +: 8] = PAD_BYTE;
      end
    end
  end

  // Block when a block closes into an occupied slot; resume once the slot drains
  always_comb begin
    state_next = state;
    case (state)
      FILLING: if (close && !slot_free) state_next = BLOCKED;
      BLOCKED: if (slot_free)           state_next = FILLING;
      default:                          state_next = FILLING;
    endcase
  end

  // Fill-side state register
  always_ff @(posedge clk) begin
    if (!reset) state <= FILLING;
    else        state <= state_next;
  end

  // Write accepted bytes into the fill buffer and advance the lane index
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx      <= '0;
      fill_buf <= '0;
    end else if (accept) begin
      fill_buf <= fill_written;
      idx      <= close ? '0 : idx + 1'b1;
    end
  end

  // Count blocks taken by the cipher core, wrapping naturally
  always_ff @(posedge clk) begin
    if (!reset)       block_count <= '0;
    else if (handoff) block_count <= block_count + 1'b1;
  end

  aes_block_slot u_slot (
    .clk        (clk),
    .reset      (reset),
    .load       (transfer),
    .load_block (load_block),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .out_valid  (out_valid),
    .slot_free  (slot_free)
  );

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed testbench for aes_block_loader: reset, streaming, back-pressure,
// simultaneous close/hand-off, mid-block reset, counter wrap, and the
// AES_LOADER_LAST_EN early close when that macro is defined.
module tb_aes_block_loader;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   in_byte = 8'h00;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         in_last = 1'b0;
  logic [127:0] out_block;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [7:0]   block_count;

  int check_count = 0;
  int pass_count  = 0;
  int ready_drops = 0;

  always #5 clk = ~clk;

  aes_block_loader #(.PAD_BYTE(8'h00), .CNT_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_byte     (in_byte),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
`ifdef AES_LOADER_LAST_EN
    .in_last     (in_last),
`endif
    .out_block   (out_block),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .block_count (block_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    else pass_count++;
  endtask

  // Present one byte for exactly one clock edge
  task automatic applyStimulus(input logic [7:0] b, input logic last);
    if (!in_ready) ready_drops++;
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic sendRun(input logic [7:0] start, input int n);
    for (int k = 0; k < n; k++) applyStimulus(start + 8'(k), 1'b0);
  endtask

  task automatic doReset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    out_ready = 1'b0;
    doReset();
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_block_count", 128'(block_count), 128'd0);
    checkOutput("rst_out_block", out_block, 128'h0);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd1);

    // Stream 00,11,..,FF with out_ready high
    out_ready = 1'b1;
    for (int k = 0; k < 15; k++) applyStimulus(8'(k * 17), 1'b0);
    checkOutput("t1_no_early_valid", 128'(out_valid), 128'd0);
    applyStimulus(8'hFF, 1'b0);
    checkOutput("t1_out_valid", 128'(out_valid), 128'd1);
    checkOutput("t1_out_block", out_block, 128'h00112233445566778899aabbccddeeff);
    tick();
    checkOutput("t1_block_count", 128'(block_count), 128'd1);
    checkOutput("t1_valid_cleared", 128'(out_valid), 128'd0);

    // 48 bytes back-to-back: three blocks, no back-pressure
    doReset();
    out_ready   = 1'b1;
    ready_drops = 0;
    sendRun(8'h00, 48);
    checkOutput("t2_block3", out_block, 128'h202122232425262728292a2b2c2d2e2f);
    tick();
    checkOutput("t2_ready_drops", 128'(ready_drops), 128'd0);
    checkOutput("t2_block_count", 128'(block_count), 128'd3);

    // Back-pressure: 32 bytes with out_ready low
    out_ready = 1'b0;
    sendRun(8'h40, 31);
    checkOutput("t3_ready_before_32", 128'(in_ready), 128'd1);
    applyStimulus(8'h5F, 1'b0);
    checkOutput("t3_ready_dropped", 128'(in_ready), 128'd0);
    checkOutput("t3_hold_block1", out_block, 128'h404142434445464748494a4b4c4d4e4f);
    tick();
    checkOutput("t3_still_block1", out_block, 128'h404142434445464748494a4b4c4d4e4f);
    checkOutput("t3_still_blocked", 128'(in_ready), 128'd0);
    checkOutput("t3_count_held", 128'(block_count), 128'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("t3_block2", out_block, 128'h505152535455565758595a5b5c5d5e5f);
    checkOutput("t3_block2_valid", 128'(out_valid), 128'd1);
    checkOutput("t3_ready_back", 128'(in_ready), 128'd1);
    checkOutput("t3_count_4", 128'(block_count), 128'd4);

    // Closing byte, hand-off and slot reload on the same edge
    sendRun(8'h60, 15);
    out_ready = 1'b1;
    applyStimulus(8'h6F, 1'b0);
    checkOutput("t3b_valid_kept", 128'(out_valid), 128'd1);
    checkOutput("t3b_new_block", out_block, 128'h606162636465666768696a6b6c6d6e6f);
    checkOutput("t3b_in_ready", 128'(in_ready), 128'd1);
    checkOutput("t3b_count_5", 128'(block_count), 128'd5);
    tick();
    checkOutput("t3b_count_6", 128'(block_count), 128'd6);

    // Reset mid-block with a full slot discards everything
    out_ready = 1'b0;
    sendRun(8'h80, 16);
    sendRun(8'hE0, 7);
    doReset();
    checkOutput("t4_out_valid", 128'(out_valid), 128'd0);
    checkOutput("t4_block_count", 128'(block_count), 128'd0);
    checkOutput("t4_in_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    sendRun(8'hC0, 16);
    checkOutput("t4_clean_block", out_block, 128'hc0c1c2c3c4c5c6c7c8c9cacbcccdcecf);
    tick();

`ifdef AES_LOADER_LAST_EN
    // Early close pads the remaining lanes
    doReset();
    out_ready = 1'b0;
    applyStimulus(8'hAA, 1'b0);
    applyStimulus(8'hBB, 1'b0);
    applyStimulus(8'hCC, 1'b1);
    checkOutput("t5_last_valid", 128'(out_valid), 128'd1);
    checkOutput("t5_last_block", out_block, 128'hAABBCC00_00000000_00000000_00000000);
    out_ready = 1'b1;
    tick();
    sendRun(8'h10, 16);
    checkOutput("t5_next_block", out_block, 128'h101112131415161718191a1b1c1d1e1f);
    tick();
`endif

    // Counter wrap after 256 hand-offs
    doReset();
    out_ready = 1'b1;
    sendRun(8'h00, 255 * 16);
    tick();
    checkOutput("t6_count_255", 128'(block_count), 128'd255);
    sendRun(8'h00, 16);
    tick();
    checkOutput("t6_count_wrap", 128'(block_count), 128'd0);

    $display("[TB] %0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Byte-stream front end for the AES encrypt/decrypt cores. It accepts plaintext or ciphertext one byte at a time over a valid/ready handshake and packs 16 bytes into a 128-bit block. It then presents the block to the cipher core over a second valid/ready handshake. It replaces the fixed hard-wired message at the cipher input and double-buffers, so one block can fill while the previous block waits for the core.

## Interface
- PAD_BYTE, 8'h00, value written into unfilled byte lanes when a block is closed early (only used with AES_LOADER_LAST_EN).
- CNT_W, 8, width of the completed-block counter.

- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- in_byte  in  8  input byte.
- in_valid  in  1  in_byte valid.
- in_ready  out  1  loader can accept a byte this cycle.
- in_last  in  1  closes the current block early. Present only with AES_LOADER_LAST_EN.
- out_block  out  128  assembled block. The first byte received occupies bits [127:120].
- out_valid  out  1  out_block valid.
- out_ready  in  1  cipher core accepts out_block.
- block_count  out  CNT_W  number of blocks handed off; wraps modulo 2^CNT_W.

## Operation
- Fill buffer: 128-bit register plus a 4-bit byte index idx (0..15) and a fill_full flag.
- Output slot: 128-bit register plus out_valid.
- Byte accept = in_valid && in_ready.
  - On accept, in_byte is written to lane idx. Lane 0 is bits [127:120]; lane 15 is bits [7:0].
  - idx then increments.
- Block close: occurs on accept with idx==15.
  - idx wraps to 0 on close.
- Transfer fill -> slot: occurs when the fill is complete (closing this cycle or fill_full) and the slot is free.
  - The slot is free when !out_valid, or when out_valid && out_ready this cycle.
  - If a block closes and the slot is not free, fill_full is set.
  - On transfer, fill_full clears and out_valid sets.
- in_ready = !fill_full.
  - It does not depend on in_valid, and it drops in the cycle after the closing byte if the slot stayed occupied.
- Hand-off = out_valid && out_ready. On hand-off:
  - out_valid clears, unless a transfer occurs in the same cycle, in which case it stays high with the new block.
  - block_count increments.
- Stability: out_block must not change while out_valid=1 and out_ready=0.
- Fill-buffer lanes not yet written in the current block hold stale data. They are never exposed, because every exposed block has all 16 lanes written (or padded).
- State summary: FILLING (fill_full=0) and BLOCKED (fill_full=1), crossed with slot EMPTY/FULL.
  - FILLING -> BLOCKED: block closes while the slot is FULL and not draining.
  - BLOCKED -> FILLING: hand-off occurs.

## Timing
- Reset (reset==0 at a clk edge) forces idx=0, fill_full=0, out_valid=0, out_block=128'h0, block_count=0. in_ready is 1 from the first cycle after release.
- A reset mid-block discards partial and buffered blocks with no hand-off.
- Latency: the closing byte is accepted at edge N. If the slot is free, out_valid=1 after edge N with the full block, giving 1 cycle.
- Throughput: one byte per cycle sustained while out_ready is held high. Fill cycles cover the hand-off, so there are no bubbles.
- Simultaneous events: in the same cycle, a closing byte, a hand-off of the old slot block, and the new block loading into the slot are all legal. block_count increments once.
- BLOCKED exit: hand-off at edge M gives in_ready=1 after M, and the buffered block is in the slot after M.
- block_count wraps from 2^CNT_W-1 to 0.

## Configuration
- AES_LOADER_LAST_EN defined:
  - Adds the in_last port.
  - An accept with in_last=1 at any idx closes the block. Lanes idx+1..15 are filled with PAD_BYTE and idx returns to 0.
  - An accept with in_last=1 at idx==15 is identical to a normal close.
- AES_LOADER_LAST_EN undefined: the in_last port is absent, blocks close only at idx==15, and PAD_BYTE is unused.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_BITS=128 and AES_BLOCK_BYTES=16 constants.
  - typedef aes_block_t (logic [127:0]).
  - typedef aes_byte_idx_t (logic [3:0]).
- One sub-module is natural: aes_block_slot, the output register with valid/ready hold semantics, reusable on the cipher output side.

## Test plan
- Reset, then stream 00,11,...,FF on consecutive cycles with out_ready=1 -> out_block=128'h00112233445566778899aabbccddeeff and out_valid=1 exactly one cycle after the byte FF; then block_count=1.
- Stream 48 bytes back-to-back with out_ready=1 -> three blocks, in_ready never low, block_count=3.
- Hold out_ready=0 and send 32 bytes -> in_ready drops after the 32nd byte; out_block holds block 1. Raise out_ready for one cycle -> block 2 appears the next cycle and in_ready=1.
- Drive reset low after 7 bytes -> out_valid=0, block_count=0. The next 16 bytes form a clean block with no stale lanes.
- With AES_LOADER_LAST_EN and PAD_BYTE=8'h00, send AA,BB,CC with in_last on CC -> out_block=128'hAABBCC00_00000000_00000000_00000000.
- Preload block_count=255 via 255 hand-offs (CNT_W=8), then one more hand-off -> block_count=0.
